// File: rtl/cprv_hazard_ctrl.sv
// cprv_hazard_ctrl: register-write scoreboard and ID->EX issue gate.
// One saturating pending-write counter per architectural register (x0 untracked)
// plus a global in-flight count. ID is held on RAW against a pending write, on a
// destination whose counter is full, or when the in-flight budget is exhausted.
module cprv_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int CNT_WIDTH    = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_id_i,
  input  logic [AW-1:0]       rs1_addr_i,
  input  logic [AW-1:0]       rs2_addr_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic [AW-1:0]       rd_addr_i,
  input  logic                rd_en_i,
  input  logic                ready_ex_i,
  input  logic                wb_valid_i,
  input  logic [AW-1:0]       wb_rd_addr_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                valid_ex_o,
  output logic                ready_id_o,
  output logic                issue_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [IW-1:0]       inflight_o,
  output logic                err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;

  logic raw1, raw2, waw_full, cap;
  logic rd_trk, trk_issue, trk_retire, wb_orphan;

  // Hazard detection and handshake gating, from registered state only
  always_comb begin
    rd_trk   = rd_en_i && (rd_addr_i != '0);
    raw1     = rs1_used_i && (rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != '0);
    raw2     = rs2_used_i && (rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != '0);
    waw_full = rd_trk && (cnt_q[rd_addr_i] == CNT_MAX);
    cap      = rd_trk && (inflight_q == IW'(MAX_INFLIGHT));
    stall_o    = valid_id_i && (raw1 || raw2 || waw_full || cap);
    valid_ex_o = valid_id_i && !stall_o;
    ready_id_o = ready_ex_i && !stall_o;
    issue_o    = valid_ex_o && ready_ex_i;
    trk_issue  = issue_o && rd_trk;
    trk_retire = wb_valid_i && (wb_rd_addr_i != '0) && (cnt_q[wb_rd_addr_i] != '0);
    wb_orphan  = wb_valid_i && (wb_rd_addr_i != '0) && (cnt_q[wb_rd_addr_i] == '0);
  end

  // Next-state for counters, in-flight total and sticky error; flush wins
  always_comb begin
    logic inc_r, dec_r;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    err_d      = err_q || wb_orphan;
    inc_r      = 1'b0;
    dec_r      = 1'b0;
    cnt_d[0]   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_r = trk_issue  && (rd_addr_i    == AW'(r));
      dec_r = trk_retire && (wb_rd_addr_i == AW'(r));
      if (inc_r && !dec_r)      cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      else if (dec_r && !inc_r) cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
    end
    if (trk_issue && !trk_retire)      inflight_d = inflight_q + IW'(1);
    else if (trk_retire && !trk_issue) inflight_d = inflight_q - IW'(1);
    if (flush_i) begin
      cnt_d      = '0;
      inflight_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Status outputs
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pending_o[r] = (cnt_q[r] != '0);
    inflight_o = inflight_q;
    err_o      = err_q;
  end

endmodule

// File: tb/tb_cprv_hazard_ctrl.sv
// Directed self-checking bench for cprv_hazard_ctrl.
module tb_cprv_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id_i, rs1_used_i, rs2_used_i, rd_en_i, ready_ex_i;
  logic        wb_valid_i, flush_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, wb_rd_addr_i;
  logic        stall_o, valid_ex_o, ready_id_o, issue_o, err_o;
  logic [31:0] pending_o;
  logic [2:0]  inflight_o;
  int checks = 0;
  int failures = 0;

  cprv_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_id_i(valid_id_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i), .ready_ex_i(ready_ex_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .flush_i(flush_i),
    .stall_o(stall_o), .valid_ex_o(valid_ex_o), .ready_id_o(ready_id_o),
    .issue_o(issue_o), .pending_o(pending_o), .inflight_o(inflight_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    valid_id_i = 0; rs1_used_i = 0; rs2_used_i = 0; rd_en_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0; ready_ex_i = 1;
    wb_valid_i = 0; wb_rd_addr_i = 0; flush_i = 0;
  endtask

  // Advance one edge; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    valid_id_i = 1; rd_en_i = 1; rd_addr_i = rd; rs1_used_i = 0; rs2_used_i = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
    checks++; if (valid_ex_o !== 1'b0 || issue_o !== 1'b0) begin failures++; $display("FAIL reset_valid_issue got=%0b%0b exp=00", valid_ex_o, issue_o); end
    checks++; if (ready_id_o !== 1'b1) begin failures++; $display("FAIL reset_ready_id_hi got=%0b exp=1", ready_id_o); end
    ready_ex_i = 0; #1;
    checks++; if (ready_id_o !== 1'b0) begin failures++; $display("FAIL reset_ready_id_lo got=%0b exp=0", ready_id_o); end
    checks++; if (pending_o !== 32'h0 || inflight_o !== 3'd0 || err_o !== 1'b0) begin failures++; $display("FAIL reset_state got=%h/%0d/%0b exp=0/0/0", pending_o, inflight_o, err_o); end
    ready_ex_i = 1;
    tick(); rst_n = 1; tick();
  endtask

  task automatic test_raw();
    idle(); issue_rd(5); #1;
    checks++; if (issue_o !== 1'b1) begin failures++; $display("FAIL raw_issue1 got=%0b exp=1", issue_o); end
    tick();
    rd_en_i = 0; rs1_used_i = 1; rs1_addr_i = 5; #1;
    checks++; if (stall_o !== 1'b1 || issue_o !== 1'b0 || valid_ex_o !== 1'b0 || ready_id_o !== 1'b0) begin failures++; $display("FAIL raw_stall got=%0b%0b%0b%0b exp=1000", stall_o, issue_o, valid_ex_o, ready_id_o); end
    checks++; if (pending_o !== 32'h20 || inflight_o !== 3'd1) begin failures++; $display("FAIL raw_pending got=%h/%0d exp=20/1", pending_o, inflight_o); end
    wb_valid_i = 1; wb_rd_addr_i = 5; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL raw_wb_same_cycle got=%0b exp=1", stall_o); end
    tick(); wb_valid_i = 0; #1;
    checks++; if (stall_o !== 1'b0 || issue_o !== 1'b1) begin failures++; $display("FAIL raw_release got=%0b%0b exp=01", stall_o, issue_o); end
    checks++; if (pending_o !== 32'h0 || inflight_o !== 3'd0 || err_o !== 1'b0) begin failures++; $display("FAIL raw_cleared got=%h/%0d/%0b exp=0/0/0", pending_o, inflight_o, err_o); end
    tick(); idle();
  endtask

  task automatic test_cap();
    idle();
    for (int r = 1; r <= 4; r++) begin
      issue_rd(5'(r)); #1;
      checks++; if (issue_o !== 1'b1) begin failures++; $display("FAIL cap_issue_%0d got=%0b exp=1", r, issue_o); end
      tick();
    end
    issue_rd(6); #1;
    checks++; if (inflight_o !== 3'd4 || pending_o !== 32'h1E) begin failures++; $display("FAIL cap_fill got=%0d/%h exp=4/1e", inflight_o, pending_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL cap_stall got=%0b exp=1", stall_o); end
    wb_valid_i = 1; wb_rd_addr_i = 3; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL cap_wb_same_cycle got=%0b exp=1", stall_o); end
    tick(); wb_valid_i = 0; #1;
    checks++; if (stall_o !== 1'b0 || inflight_o !== 3'd3 || pending_o !== 32'h16) begin failures++; $display("FAIL cap_release got=%0b/%0d/%h exp=0/3/16", stall_o, inflight_o, pending_o); end
    tick(); idle(); #1;
    checks++; if (inflight_o !== 3'd4 || pending_o !== 32'h56) begin failures++; $display("FAIL cap_refill got=%0d/%h exp=4/56", inflight_o, pending_o); end
    flush_i = 1; tick(); flush_i = 0; #1;
    checks++; if (inflight_o !== 3'd0 || pending_o !== 32'h0) begin failures++; $display("FAIL cap_flush got=%0d/%h exp=0/0", inflight_o, pending_o); end
  endtask

  task automatic test_same_cycle();
    idle(); issue_rd(7); tick();
    issue_rd(7); wb_valid_i = 1; wb_rd_addr_i = 7; tick();
    idle(); #1;
    checks++; if (inflight_o !== 3'd1 || pending_o !== 32'h80) begin failures++; $display("FAIL same_reg got=%0d/%h exp=1/80", inflight_o, pending_o); end
    issue_rd(8); wb_valid_i = 1; wb_rd_addr_i = 7; tick();
    idle(); #1;
    checks++; if (inflight_o !== 3'd1 || pending_o !== 32'h100) begin failures++; $display("FAIL diff_reg got=%0d/%h exp=1/100", inflight_o, pending_o); end
    wb_valid_i = 1; wb_rd_addr_i = 8; tick(); idle(); #1;
    checks++; if (inflight_o !== 3'd0 || pending_o !== 32'h0 || err_o !== 1'b0) begin failures++; $display("FAIL diff_drain got=%0d/%h/%0b exp=0/0/0", inflight_o, pending_o, err_o); end
    issue_rd(0); rs1_used_i = 1; rs1_addr_i = 0; wb_valid_i = 1; wb_rd_addr_i = 0; #1;
    checks++; if (stall_o !== 1'b0 || issue_o !== 1'b1) begin failures++; $display("FAIL x0_issue got=%0b%0b exp=01", stall_o, issue_o); end
    tick(); idle(); #1;
    checks++; if (inflight_o !== 3'd0 || pending_o !== 32'h0 || err_o !== 1'b0) begin failures++; $display("FAIL x0_untracked got=%0d/%h/%0b exp=0/0/0", inflight_o, pending_o, err_o); end
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 3; k++) begin issue_rd(9); tick(); end
    issue_rd(9); #1;
    checks++; if (inflight_o !== 3'd3 || stall_o !== 1'b1) begin failures++; $display("FAIL waw_full got=%0d/%0b exp=3/1", inflight_o, stall_o); end
    issue_rd(12); flush_i = 1; #1;
    checks++; if (issue_o !== 1'b1) begin failures++; $display("FAIL flush_issue got=%0b exp=1", issue_o); end
    rd_en_i = 0; rs1_used_i = 1; rs1_addr_i = 9; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL flush_stall_eval got=%0b exp=1", stall_o); end
    rd_en_i = 1; rs1_used_i = 0; tick(); idle(); #1;
    checks++; if (inflight_o !== 3'd0 || pending_o !== 32'h0 || err_o !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0d/%h/%0b exp=0/0/0", inflight_o, pending_o, err_o); end
    wb_valid_i = 1; wb_rd_addr_i = 9; tick(); idle(); #1;
    checks++; if (err_o !== 1'b1 || inflight_o !== 3'd0) begin failures++; $display("FAIL orphan_err got=%0b/%0d exp=1/0", err_o, inflight_o); end
    tick(); tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err_o); end
  endtask

  task automatic test_ready_low();
    idle(); issue_rd(13); ready_ex_i = 0; #1;
    checks++; if (valid_ex_o !== 1'b1 || issue_o !== 1'b0 || ready_id_o !== 1'b0) begin failures++; $display("FAIL rdy_low got=%0b%0b%0b exp=100", valid_ex_o, issue_o, ready_id_o); end
    tick(); #1;
    checks++; if (inflight_o !== 3'd0 || pending_o !== 32'h0) begin failures++; $display("FAIL rdy_low_nochange got=%0d/%h exp=0/0", inflight_o, pending_o); end
    idle();
  endtask

  task automatic test_async_reset();
    idle(); issue_rd(14); tick(); issue_rd(15); tick(); idle(); #1;
    checks++; if (inflight_o !== 3'd2 || err_o !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%0b exp=2/1", inflight_o, err_o); end
    rst_n = 0; #1;
    checks++; if (inflight_o !== 3'd0 || pending_o !== 32'h0 || err_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%h/%0b/%0b exp=0/0/0/0", inflight_o, pending_o, err_o, stall_o); end
    #1 rst_n = 1; tick();
    wb_valid_i = 1; wb_rd_addr_i = 14; tick(); idle(); #1;
    checks++; if (err_o !== 1'b1 || inflight_o !== 3'd0) begin failures++; $display("FAIL post_reset_wb got=%0b/%0d exp=1/0", err_o, inflight_o); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_cap();
    test_same_cycle();
    test_flush();
    test_ready_low();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/cprv_hazard_ctrl.md
Name: cprv_hazard_ctrl

Overview:
Scoreboard and issue controller for the ID→EX boundary. Tracks outstanding register-file writes between issue and writeback. Holds an instruction in ID while it reads, or writes, a register that still has a pending write. Gates the ID/EX valid/ready handshake, so no stale rs1/rs2 data reaches EX.

Parameters:
NUM_REGS, 32, architectural integer registers; x0 is never tracked.
CNT_WIDTH, 2, width of each per-register pending-write counter (max 2^CNT_WIDTH-1 outstanding writes per register).
MAX_INFLIGHT, 4, maximum total outstanding writes across all registers.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_id_i  input  1  ID holds a decoded instruction
rs1_addr_i  input  5  source register 1 of the ID instruction
rs2_addr_i  input  5  source register 2 of the ID instruction
rs1_used_i  input  1  instruction reads rs1
rs2_used_i  input  1  instruction reads rs2
rd_addr_i  input  5  destination register of the ID instruction
rd_en_i  input  1  instruction writes rd
ready_ex_i  input  1  EX can accept an instruction this cycle
wb_valid_i  input  1  writeback retires a register write this cycle
wb_rd_addr_i  input  5  register written by writeback
flush_i  input  1  pipeline flush; all in-flight writes are discarded
stall_o  output  1  hazard hold: ID must not issue
valid_ex_o  output  1  qualified valid toward EX (valid_id_i & ~stall_o)
ready_id_o  output  1  ID may advance (ready_ex_i & ~stall_o)
issue_o  output  1  issue fire pulse (valid_ex_o & ready_ex_i)
pending_o  output  NUM_REGS  bit r set iff counter r non-zero
inflight_o  output  3  total outstanding writes (sized for MAX_INFLIGHT=4)
err_o  output  1  sticky: writeback to a register with no pending write

Behaviour:
- Reset (rst_n low, async): all counters 0, inflight_o=0, err_o=0. All outputs are then 0 except ready_id_o, which equals ready_ex_i.
- Hazard terms are computed from registered state only. A same-cycle writeback does not release a stall; the stall clears the cycle after.
  - raw1 = rs1_used_i & rs1_addr_i!=0 & cnt[rs1_addr_i]!=0; raw2 likewise for rs2.
  - waw_full = rd_en_i & rd_addr_i!=0 & cnt[rd_addr_i]==max.
  - cap = rd_en_i & rd_addr_i!=0 & inflight_o==MAX_INFLIGHT.
  - stall_o = valid_id_i & (raw1|raw2|waw_full|cap).
- stall_o, valid_ex_o, ready_id_o and issue_o are purely combinational, with zero-cycle latency from inputs.
- A tracked issue is issue_o & rd_en_i & rd_addr_i!=0. It increments cnt[rd] and inflight_o at the next edge.
- A tracked retire is wb_valid_i & wb_rd_addr_i!=0 & cnt[wb_rd_addr_i]!=0. It decrements cnt and inflight_o at the next edge.
- Issue and retire to the same register in the same cycle: the counter is unchanged and inflight_o is unchanged.
- Issue and retire to different registers in the same cycle: each counter is updated independently, and inflight_o is unchanged.
- wb_valid_i to a register whose counter is 0: no counter change, err_o is set and stays 1 until reset. wb to x0 is ignored silently.
- flush_i: at the next edge all counters and inflight_o become 0, and flush takes priority over a same-cycle issue or retire. err_o is unaffected. stall_o is still evaluated from the current state during the flush cycle.
- Counters saturate by construction; waw_full and cap prevent overflow. There is no wrap-around.
- Reset asserted mid-operation clears all state immediately; pending writebacks that arrive afterwards set err_o.

Test Plan:
- After reset, issue rd=5 (valid_id_i=1, ready_ex_i=1), then an instruction reading rs1=5 → cycle1: issue_o=1; cycle2: stall_o=1, pending_o[5]=1, inflight_o=1.
- Continuing that case, wb_valid_i=1 with wb_rd_addr_i=5 in cycle3 → stall_o stays 1 in cycle3, drops in cycle4, issue_o=1 in cycle4 (ready_ex_i=1), pending_o[5]=0.
- Issue writes to rd=1,2,3,4 back to back with no wb, then an instruction with rd=6 → inflight_o=4, stall_o=1 (cap). One wb to x3 → cap stall clears the next cycle.
- Same cycle: issue rd=7 plus wb rd=7 while cnt[7]=1 → cnt[7] stays 1, inflight_o unchanged. Rd=0 and rs1=0 with a x0 writeback → no tracking, no stall, err_o=0.
- Three pending writes in flight, then flush_i=1 together with an issue → next cycle inflight_o=0 and pending_o=0. A later wb to x9 → err_o=1, sticky.
- ready_ex_i=0 with no hazard → valid_ex_o=1, issue_o=0, no counter change. Deassert rst_n mid-sequence → all outputs clear asynchronously, before the next clock edge.
